// File: rtl/spi_master_ctrl_if.sv
// Word request / response handshake between a client and the SPI master controller.
// The controller sits on the slave modport; the requesting client uses the master modport.
interface spi_master_ctrl_if #(
    parameter int DW = 32
) ();
    logic          req_valid_i;
    logic          req_ready_o;
    logic [DW-1:0] req_data_i;
    logic          req_last_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_data_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: one word per request with runtime CPOL/CPHA, divider and length.
// Slave select is held across words until a request marked last completes.
module spi_master_ctrl #(
    parameter int SSN = 3,
    parameter int DW  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      cfg_div_i,
    input  logic             cfg_cpol_i,
    input  logic             cfg_cpha_i,
    input  logic [4:0]       cfg_len_i,
    input  logic [1:0]       cfg_ss_i,
    spi_master_ctrl_if.slave bus,
    output logic             busy_o,
    output logic             sclk_o,
    output logic             sclk_t,
    input  logic             sclk_i,
    output logic             mosi_o,
    output logic             mosi_t,
    input  logic             mosi_i,
    input  logic             miso_i,
    output logic             miso_o,
    output logic             miso_t,
    output logic             ss_o,
    output logic             ss_t,
    input  logic             ss_i,
    output logic             ss1_o,
    output logic             ss2_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]     state;
    logic [16:0]    cnt;
    logic [6:0]     edge_cnt;
    logic [4:0]     bit_idx;
    logic [4:0]     len_q;
    logic [15:0]    div_q;
    logic           cpol_q;
    logic           cpha_q;
    logic           last_q;
    logic [DW-1:0]  tx_q;
    logic [DW-1:0]  rx_q;
    logic [SSN-1:0] ss_q;
    logic [SSN-1:0] ss_sel;
    logic           sclk_q;
    logic           mosi_q;
    logic           rsp_valid_q;
    logic [DW-1:0]  rsp_data_q;
    logic           ready;
    logic           accept;
    logic           cnt_zero;
    logic           leading;
    logic           last_edge;
    logic           unused_inputs;

    assign unused_inputs = ^{sclk_i, mosi_i, ss_i};

    assign ready     = ~rst_i & ((state == S_IDLE) | (state == S_WAIT));
    assign accept    = bus.req_valid_i & ready;
    assign cnt_zero  = (cnt == 17'd0);
    assign leading   = ~edge_cnt[0];
    // edge_cnt holds edges already produced; the final one of 2N is pending when it equals 2N-1
    assign last_edge = (edge_cnt == ({1'b0, len_q, 1'b0} + 7'd1));

    always_comb begin
        ss_sel = '1;
        if (cfg_ss_i != 2'd3) begin
            ss_sel[cfg_ss_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            edge_cnt    <= '0;
            bit_idx     <= '0;
            len_q       <= '0;
            div_q       <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            last_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            ss_q        <= '1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    sclk_q <= cfg_cpol_i;
                    if (accept) begin
                        div_q    <= cfg_div_i;
                        cpol_q   <= cfg_cpol_i;
                        cpha_q   <= cfg_cpha_i;
                        len_q    <= cfg_len_i;
                        ss_q     <= ss_sel;
                        tx_q     <= bus.req_data_i;
                        last_q   <= bus.req_last_i;
                        cnt      <= {1'b0, cfg_div_i};
                        edge_cnt <= '0;
                        bit_idx  <= cfg_len_i;
                        rx_q     <= '0;
                        if (!cfg_cpha_i) begin
                            mosi_q <= bus.req_data_i[cfg_len_i];
                        end
                        state <= S_SETUP;
                    end
                end
                S_SETUP, S_SHIFT: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 17'd1;
                    end else begin
                        cnt      <= {1'b0, div_q};
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + 7'd1;
                        state    <= last_edge ? S_HOLD : S_SHIFT;
                        if (leading) begin
                            if (cpha_q) begin
                                mosi_q <= tx_q[bit_idx];
                            end else begin
                                rx_q <= {rx_q[DW-2:0], miso_i};
                            end
                        end else begin
                            if (cpha_q) begin
                                rx_q <= {rx_q[DW-2:0], miso_i};
                            end else if (bit_idx != 5'd0) begin
                                mosi_q <= tx_q[bit_idx - 5'd1];
                            end
                            if (bit_idx != 5'd0) begin
                                bit_idx <= bit_idx - 5'd1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 17'd1;
                    end else begin
                        cnt         <= {1'b0, div_q};
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_q;
                        if (last_q) begin
                            ss_q  <= '1;
                            state <= S_GAP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_GAP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 17'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Frame configuration stays frozen; only the next word is taken
                    if (accept) begin
                        tx_q     <= bus.req_data_i;
                        last_q   <= bus.req_last_i;
                        cnt      <= {1'b0, div_q};
                        edge_cnt <= '0;
                        bit_idx  <= len_q;
                        rx_q     <= '0;
                        if (!cpha_q) begin
                            mosi_q <= bus.req_data_i[len_q];
                        end
                        state <= S_SETUP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign busy_o          = (state != S_IDLE);
    assign sclk_o          = sclk_q;
    assign sclk_t          = 1'b0;
    assign mosi_o          = mosi_q;
    assign mosi_t          = (state == S_IDLE);
    assign miso_o          = 1'b0;
    assign miso_t          = 1'b1;
    assign ss_o            = ss_q[0];
    assign ss1_o           = ss_q[1];
    assign ss2_o           = ss_q[2];
    assign ss_t            = 1'b0;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: table of single-word frames, then
// hand-written multi-word, reset-abort and maximum-divider sequences.
module tb_spi_master_ctrl;

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [4:0]  len;
        logic [15:0] div;
        logic [1:0]  ss;
        logic [31:0] data;
        int          msel;
        logic        mconst;
        logic [31:0] exp_rsp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_div;
    logic        cfg_cpol;
    logic        cfg_cpha;
    logic [4:0]  cfg_len;
    logic [1:0]  cfg_ss;
    logic        busy;
    logic        sclk_o, sclk_t, sclk_i;
    logic        mosi_o, mosi_t, mosi_i;
    logic        miso_i, miso_o, miso_t;
    logic        ss_o, ss_t, ss_i, ss1_o, ss2_o;
    logic [2:0]  ssv;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // Frame statistics gathered once per cycle by tick()
    logic        sclk_prev;
    logic [2:0]  ss_prev;
    int          n_tog, n_rise, first_tog, last_tog;
    int          n_rsp, rsp_cyc, rdy_cyc;
    int          low_cnt[3];
    int          tog_cnt[3];
    logic [31:0] rsp_hist[4];

    int          msel = 0;
    logic        mconst = 1'b0;
    logic        slv_miso = 1'b0;
    logic [31:0] slv_word = 32'h12345678;
    logic [31:0] slv_rx = '0;
    int          sidx = 0;
    int          cur_len = 0;
    logic        cur_cpol = 1'b0;
    logic        cur_cpha = 1'b0;
    logic        slv_ss_q, slv_sclk_q, lead;

    vec_t        vecs[9];

    spi_master_ctrl_if #(.DW(32)) bus ();

    spi_master_ctrl #(.SSN(3), .DW(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_div_i  (cfg_div),
        .cfg_cpol_i (cfg_cpol),
        .cfg_cpha_i (cfg_cpha),
        .cfg_len_i  (cfg_len),
        .cfg_ss_i   (cfg_ss),
        .bus        (bus),
        .busy_o     (busy),
        .sclk_o     (sclk_o),
        .sclk_t     (sclk_t),
        .sclk_i     (sclk_i),
        .mosi_o     (mosi_o),
        .mosi_t     (mosi_t),
        .mosi_i     (mosi_i),
        .miso_i     (miso_i),
        .miso_o     (miso_o),
        .miso_t     (miso_t),
        .ss_o       (ss_o),
        .ss_t       (ss_t),
        .ss_i       (ss_i),
        .ss1_o      (ss1_o),
        .ss2_o      (ss2_o)
    );

    assign ssv    = {ss2_o, ss1_o, ss_o};
    assign miso_i = (msel == 0) ? mosi_o : (msel == 1) ? slv_miso : mconst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI slave on ss_o: shifts slv_word out MSB first and captures MOSI
    always @(sclk_o, ss_o) begin
        if (ss_o !== slv_ss_q) begin
            slv_ss_q = ss_o;
            if (ss_o === 1'b0) begin
                sidx   = cur_len;
                slv_rx = '0;
                if (!cur_cpha) slv_miso = slv_word[sidx];
            end
        end else if (sclk_o !== slv_sclk_q && ss_o === 1'b0) begin
            lead = (sclk_o != cur_cpol);
            if (lead) begin
                if (cur_cpha) slv_miso = slv_word[sidx];
                else slv_rx = {slv_rx[30:0], mosi_o};
            end else begin
                if (cur_cpha) begin
                    slv_rx = {slv_rx[30:0], mosi_o};
                    if (sidx > 0) sidx = sidx - 1;
                end else begin
                    if (sidx > 0) sidx = sidx - 1;
                    slv_miso = slv_word[sidx];
                end
            end
        end
        slv_sclk_q = sclk_o;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (sclk_o !== sclk_prev) begin
            n_tog++;
            if (first_tog < 0) first_tog = cyc;
            last_tog = cyc;
            if (sclk_o) n_rise++;
        end
        sclk_prev = sclk_o;
        for (int i = 0; i < 3; i++) begin
            if (ssv[i] !== ss_prev[i]) tog_cnt[i]++;
            if (ssv[i] === 1'b0) low_cnt[i]++;
        end
        ss_prev = ssv;
        if (bus.rsp_valid_o) begin
            if (n_rsp < 4) rsp_hist[n_rsp] = bus.rsp_data_o;
            n_rsp++;
            rsp_cyc = cyc;
        end
        if (bus.req_ready_o && n_rsp > 0 && rdy_cyc < 0) rdy_cyc = cyc;
    endtask

    task automatic clear_stats();
        sclk_prev = sclk_o;
        ss_prev   = ssv;
        n_tog = 0; n_rise = 0; first_tog = -1; last_tog = -1;
        n_rsp = 0; rsp_cyc = -1; rdy_cyc = -1;
        for (int i = 0; i < 3; i++) begin
            low_cnt[i] = 0;
            tog_cnt[i] = 0;
        end
    endtask

    task automatic start_req(input logic [31:0] d, input logic l, output int t);
        int g;
        g = 0;
        bus.req_data_i  = d;
        bus.req_last_i  = l;
        bus.req_valid_i = 1'b1;
        while (!bus.req_ready_o && g < 1000) begin
            tick();
            g++;
        end
        check_output("accept_wait", 64'(g < 1000), 64'd1);
        t = cyc;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int g;
        g = 0;
        while (rdy_cyc < 0 && g < budget) begin
            tick();
            g++;
        end
        check_output("frame_done", 64'(rdy_cyc >= 0), 64'd1);
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha, input logic [4:0] len,
                           input logic [15:0] div, input logic [1:0] ss);
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_len = len; cfg_div = div; cfg_ss = ss;
        cur_cpol = cpol; cur_cpha = cpha; cur_len = int'(len);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        int h, n, t, oth;
        h = int'(v.div) + 1;
        n = int'(v.len) + 1;
        set_cfg(v.cpol, v.cpha, v.len, v.div, v.ss);
        msel = v.msel;
        mconst = v.mconst;
        repeat (3) tick();
        check_output($sformatf("v%0d_idle_sclk", idx), 64'(sclk_o), 64'(v.cpol));
        clear_stats();
        start_req(v.data, 1'b1, t);
        wait_ready((2 * n + 2) * h + 20);
        check_output($sformatf("v%0d_rsp_data", idx), 64'(rsp_hist[0]), 64'(v.exp_rsp));
        check_output($sformatf("v%0d_rsp_count", idx), 64'(n_rsp), 64'd1);
        check_output($sformatf("v%0d_rsp_cycle", idx), 64'(rsp_cyc), 64'(t + 1 + (2 * n + 1) * h));
        check_output($sformatf("v%0d_ready_cycle", idx), 64'(rdy_cyc), 64'(t + 1 + (2 * n + 2) * h));
        check_output($sformatf("v%0d_edges", idx), 64'(n_tog), 64'(2 * n));
        check_output($sformatf("v%0d_rises", idx), 64'(n_rise), 64'(n));
        check_output($sformatf("v%0d_first_edge", idx), 64'(first_tog), 64'(t + 1 + h));
        check_output($sformatf("v%0d_last_edge", idx), 64'(last_tog), 64'(t + 1 + 2 * n * h));
        check_output($sformatf("v%0d_end_sclk", idx), 64'(sclk_o), 64'(v.cpol));
        check_output($sformatf("v%0d_end_mosi_t", idx), 64'(mosi_t), 64'd1);
        if (v.ss == 2'd3) begin
            check_output($sformatf("v%0d_ss_toggles", idx), 64'(tog_cnt[0] + tog_cnt[1] + tog_cnt[2]), 64'd0);
        end else begin
            oth = tog_cnt[0] + tog_cnt[1] + tog_cnt[2] - tog_cnt[v.ss];
            check_output($sformatf("v%0d_ss_low", idx), 64'(low_cnt[v.ss]), 64'((2 * n + 1) * h));
            check_output($sformatf("v%0d_ss_sel_tog", idx), 64'(tog_cnt[v.ss]), 64'd2);
            check_output($sformatf("v%0d_ss_other_tog", idx), 64'(oth), 64'd0);
        end
        if (v.msel == 1) begin
            check_output($sformatf("v%0d_slave_rx", idx), 64'(slv_rx), 64'(v.data));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t, t2;
        int g;

        vecs[0] = '{1'b0, 1'b0, 5'd7,  16'd1, 2'd0, 32'h000000A5, 0, 1'b0, 32'h000000A5};
        vecs[1] = '{1'b0, 1'b0, 5'd31, 16'd2, 2'd0, 32'hDEADBEEF, 1, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 5'd31, 16'd2, 2'd0, 32'hDEADBEEF, 1, 1'b0, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 5'd31, 16'd2, 2'd0, 32'hDEADBEEF, 1, 1'b0, 32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 5'd31, 16'd2, 2'd0, 32'hDEADBEEF, 1, 1'b0, 32'h12345678};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  16'd0, 2'd1, 32'h00000000, 2, 1'b1, 32'h00000001};
        vecs[6] = '{1'b1, 1'b1, 5'd0,  16'd0, 2'd2, 32'h00000001, 0, 1'b0, 32'h00000001};
        vecs[7] = '{1'b1, 1'b0, 5'd11, 16'd3, 2'd3, 32'hFFFFFABC, 0, 1'b0, 32'h00000ABC};
        vecs[8] = '{1'b0, 1'b1, 5'd4,  16'd0, 2'd0, 32'h00000015, 0, 1'b0, 32'h00000015};

        rst = 1'b1;
        sclk_i = 1'b0; mosi_i = 1'b0; ss_i = 1'b1;
        set_cfg(1'b0, 1'b0, 5'd0, 16'd0, 2'd0);
        bus.req_valid_i = 1'b0;
        bus.req_data_i  = '0;
        bus.req_last_i  = 1'b0;
        clear_stats();

        repeat (3) tick();
        check_output("rst_ready", 64'(bus.req_ready_o), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_ss", 64'(ssv), 64'h7);
        check_output("rst_sclk", 64'(sclk_o), 64'd0);
        check_output("rst_mosi", 64'(mosi_o), 64'd0);
        check_output("rst_mosi_t", 64'(mosi_t), 64'd1);
        check_output("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check_output("rst_rsp_data", 64'(bus.rsp_data_o), 64'd0);
        check_output("static_drivers", 64'({sclk_t, ss_t, miso_o, miso_t}), 64'h1);
        rst = 1'b0;
        tick();
        check_output("post_rst_ready", 64'(bus.req_ready_o), 64'd1);

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Two words on ss2 with a configuration change while waiting between them
        set_cfg(1'b0, 1'b0, 5'd15, 16'd1, 2'd2);
        msel = 0;
        repeat (3) tick();
        clear_stats();
        start_req(32'h1234, 1'b0, t);
        wait_ready(100);
        check_output("w1_rsp_cycle", 64'(rsp_cyc), 64'(t + 67));
        check_output("w1_wait_ready", 64'(rdy_cyc), 64'(rsp_cyc));
        check_output("w1_busy", 64'(busy), 64'd1);
        cfg_ss = 2'd0; cfg_len = 5'd3; cfg_cpol = 1'b1; cfg_div = 16'd5;
        repeat (2) tick();
        rdy_cyc = -1;
        start_req(32'hABCD, 1'b1, t2);
        wait_ready(100);
        check_output("w2_rsp_count", 64'(n_rsp), 64'd2);
        check_output("w2_rsp0", 64'(rsp_hist[0]), 64'h1234);
        check_output("w2_rsp1", 64'(rsp_hist[1]), 64'hABCD);
        check_output("w2_rsp_cycle", 64'(rsp_cyc), 64'(t2 + 67));
        check_output("w2_ready_cycle", 64'(rdy_cyc), 64'(t2 + 69));
        check_output("w2_ss2_tog", 64'(tog_cnt[2]), 64'd2);
        check_output("w2_ss01_tog", 64'(tog_cnt[0] + tog_cnt[1]), 64'd0);
        check_output("w2_edges", 64'(n_tog), 64'd64);

        // Reset abort at the 5th SCLK edge of a 16-bit mode-3 word
        set_cfg(1'b1, 1'b1, 5'd15, 16'd2, 2'd1);
        repeat (3) tick();
        clear_stats();
        start_req(32'h8001, 1'b1, t);
        g = 0;
        while (n_tog < 5 && g < 500) begin
            tick();
            g++;
        end
        check_output("abort_edge_wait", 64'(n_tog), 64'd5);
        rst = 1'b1;
        tick();
        check_output("abort_ss", 64'(ssv), 64'h7);
        check_output("abort_sclk", 64'(sclk_o), 64'd0);
        check_output("abort_mosi_t", 64'(mosi_t), 64'd1);
        check_output("abort_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check_output("abort_rsp_data", 64'(bus.rsp_data_o), 64'd0);
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_ready_in_rst", 64'(bus.req_ready_o), 64'd0);
        rst = 1'b0;
        tick();
        check_output("abort_ready_after", 64'(bus.req_ready_o), 64'd1);
        check_output("abort_idle_sclk", 64'(sclk_o), 64'd1);
        repeat (120) tick();
        check_output("abort_no_rsp", 64'(n_rsp), 64'd0);
        clear_stats();
        start_req(32'h8001, 1'b1, t);
        wait_ready(200);
        check_output("after_abort_rsp", 64'(rsp_hist[0]), 64'h8001);
        check_output("after_abort_cycle", 64'(rsp_cyc), 64'(t + 1 + 33 * 3));

        // Maximum divider: first edge 65536 cycles after SETUP entry, then abort
        set_cfg(1'b0, 1'b0, 5'd0, 16'hFFFF, 2'd0);
        repeat (3) tick();
        clear_stats();
        start_req(32'h1, 1'b1, t);
        check_output("maxdiv_ss_low", 64'(ss_o), 64'd0);
        g = 0;
        while (first_tog < 0 && g < 70000) begin
            tick();
            g++;
        end
        check_output("maxdiv_first_edge", 64'(first_tog), 64'(t + 65537));
        check_output("maxdiv_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_output("maxdiv_abort_idle", 64'({busy, ssv}), 64'h7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
